// File: rtl/quad_encoder_emulator.sv
// Quadrature encoder emulator: emits N Gray-coded A/B edges, P clocks apart.
// Tracks a signed count of the edges it has emitted.
module quad_encoder_emulator #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned DIV_W = 16,
  parameter int unsigned POS_W = 32
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic [DIV_W-1:0] cmd_period,
  input  logic             abort,
  output logic [1:0]       enc_out,
  output logic             busy,
  output logic             done_pulse,
  output logic [POS_W-1:0] position
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic             dir_q, dir_nxt;
  logic [DIV_W-1:0] period_q, period_nxt;
  logic [DIV_W-1:0] div_q, div_nxt;
  logic [CNT_W-1:0] remain_q, remain_nxt;
  logic [1:0]       enc_nxt;
  logic [POS_W-1:0] pos_nxt;
  logic             ready_nxt, busy_nxt, done_nxt;
  logic             step;
  logic [DIV_W-1:0] period_eff;

  // A requested period of 0 behaves as 1 clock per edge.
  assign period_eff = (cmd_period == '0) ? DIV_W'(1) : cmd_period;

  // State and all registered outputs.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state      <= IDLE;
      dir_q      <= 1'b0;
      period_q   <= '0;
      div_q      <= '0;
      remain_q   <= '0;
      enc_out    <= 2'b00;
      position   <= '0;
      cmd_ready  <= 1'b0;
      busy       <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      dir_q      <= dir_nxt;
      period_q   <= period_nxt;
      div_q      <= div_nxt;
      remain_q   <= remain_nxt;
      enc_out    <= enc_nxt;
      position   <= pos_nxt;
      cmd_ready  <= ready_nxt;
      busy       <= busy_nxt;
      done_pulse <= done_nxt;
    end
  end

  // Next-state, divider/step scheduling and phase/position update.
  always_comb begin
    state_nxt  = state;
    dir_nxt    = dir_q;
    period_nxt = period_q;
    div_nxt    = div_q;
    remain_nxt = remain_q;
    enc_nxt    = enc_out;
    pos_nxt    = position;
    done_nxt   = 1'b0;
    step       = 1'b0;

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          dir_nxt    = cmd_dir;
          period_nxt = period_eff;
          div_nxt    = period_eff;
          remain_nxt = cmd_steps;
          if (cmd_steps == '0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (div_q == DIV_W'(1)) begin
          step       = 1'b1;
          div_nxt    = period_q;
          remain_nxt = remain_q - CNT_W'(1);
          if (remain_q == CNT_W'(1)) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end else begin
          div_nxt = div_q - DIV_W'(1);
        end
        // A step due on the abort edge still goes out before stopping.
        if (abort) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Gray stepping from the current phase: forward {B,A} 00->01->11->10.
    if (step) begin
      if (dir_q) begin
        enc_nxt = {enc_out[0], ~enc_out[1]};
        pos_nxt = position + POS_W'(1);
      end else begin
        enc_nxt = {~enc_out[0], enc_out[1]};
        pos_nxt = position - POS_W'(1);
      end
    end

    ready_nxt = (state_nxt == IDLE);
    busy_nxt  = (state_nxt == RUN);
  end

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Directed bench for quad_encoder_emulator; a second instance with POS_W=4
// shares all stimulus and is used to observe position wrap.
module tb_quad_encoder_emulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_dir;
  logic [15:0] cmd_steps;
  logic [15:0] cmd_period;
  logic        abort;

  logic        ready_a, busy_a, done_a;
  logic [1:0]  enc_a;
  logic [31:0] pos_a;
  logic        ready_b, busy_b, done_b;
  logic [1:0]  enc_b;
  logic [3:0]  pos_b;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  quad_encoder_emulator dut_a (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(ready_a), .cmd_dir(cmd_dir),
    .cmd_steps(cmd_steps), .cmd_period(cmd_period), .abort(abort),
    .enc_out(enc_a), .busy(busy_a), .done_pulse(done_a), .position(pos_a)
  );

  quad_encoder_emulator #(.POS_W(4)) dut_b (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(ready_b), .cmd_dir(cmd_dir),
    .cmd_steps(cmd_steps), .cmd_period(cmd_period), .abort(abort),
    .enc_out(enc_b), .busy(busy_b), .done_pulse(done_b), .position(pos_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic offer(input logic d, input logic [15:0] s, input logic [15:0] p);
    cmd_valid  = 1'b1;
    cmd_dir    = d;
    cmd_steps  = s;
    cmd_period = p;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    logic [1:0] exp_enc;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_dir = 1'b0;
    cmd_steps = '0; cmd_period = '0; abort = 1'b0;
    #12;
    chk("rst_enc",   64'(enc_a),   64'(2'b00));
    chk("rst_pos",   64'(pos_a),   64'(0));
    chk("rst_ready", 64'(ready_a), 64'(0));
    chk("rst_busy",  64'(busy_a),  64'(0));
    chk("rst_done",  64'(done_a),  64'(0));
    tick();
    chk("rst_hold_ready", 64'(ready_a), 64'(0));
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", 64'(ready_a), 64'(1));

    // dir=1, steps=4, period=3: changes at T+3,6,9,12
    offer(1'b1, 16'd4, 16'd3);
    chk("s1_busy_accept",  64'(busy_a),  64'(1));
    chk("s1_ready_accept", 64'(ready_a), 64'(0));
    exp_enc = 2'b00;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 3)  exp_enc = 2'b01;
      if (k == 6)  exp_enc = 2'b11;
      if (k == 9)  exp_enc = 2'b10;
      if (k == 12) exp_enc = 2'b00;
      chk($sformatf("s1_enc_k%0d", k),  64'(enc_a),  64'(exp_enc));
      chk($sformatf("s1_busy_k%0d", k), 64'(busy_a), 64'(k < 12));
      chk($sformatf("s1_done_k%0d", k), 64'(done_a), 64'(k == 12));
    end
    chk("s1_pos",   64'(pos_a),   64'(4));
    chk("s1_ready", 64'(ready_a), 64'(1));
    tick();
    chk("s1_done_clear", 64'(done_a), 64'(0));

    // reverse, period 0 -> 1; then back-to-back forward reversal
    do_reset();
    offer(1'b0, 16'd2, 16'd0);
    tick();
    chk("s2_enc_1",  64'(enc_a),  64'(2'b10));
    chk("s2_busy_1", 64'(busy_a), 64'(1));
    tick();
    chk("s2_enc_2",  64'(enc_a),   64'(2'b11));
    chk("s2_done",   64'(done_a),  64'(1));
    chk("s2_pos",    64'(pos_a),   64'(32'hFFFF_FFFE));
    chk("s2_ready",  64'(ready_a), 64'(1));
    offer(1'b1, 16'd1, 16'd2);
    chk("s2b_busy",  64'(busy_a), 64'(1));
    chk("s2b_done0", 64'(done_a), 64'(0));
    tick();
    chk("s2b_enc_hold", 64'(enc_a), 64'(2'b11));
    tick();
    chk("s2b_enc_rev", 64'(enc_a),  64'(2'b10));
    chk("s2b_pos",     64'(pos_a),  64'(32'hFFFF_FFFF));
    chk("s2b_done",    64'(done_a), 64'(1));

    // zero steps: no movement, immediate done, never busy
    offer(1'b1, 16'd0, 16'd7);
    chk("s3_done",  64'(done_a),  64'(1));
    chk("s3_busy",  64'(busy_a),  64'(0));
    chk("s3_ready", 64'(ready_a), 64'(1));
    chk("s3_enc",   64'(enc_a),   64'(2'b10));
    tick();
    chk("s3_done_clear", 64'(done_a), 64'(0));
    chk("s3_pos",        64'(pos_a),  64'(32'hFFFF_FFFF));

    // abort mid-run at T+12 with period 5: two edges
    do_reset();
    abort = 1'b1;
    tick();
    chk("idle_abort_ready", 64'(ready_a), 64'(1));
    abort = 1'b0;
    offer(1'b1, 16'd100, 16'd5);
    for (int k = 1; k <= 12; k++) begin
      if (k == 12) abort = 1'b1;
      tick();
      if (k == 5)  chk("s4_enc_k5",  64'(enc_a), 64'(2'b01));
      if (k == 10) chk("s4_enc_k10", 64'(enc_a), 64'(2'b11));
    end
    abort = 1'b0;
    chk("s4_done", 64'(done_a), 64'(1));
    chk("s4_busy", 64'(busy_a), 64'(0));
    chk("s4_pos",  64'(pos_a),  64'(2));
    chk("s4_enc",  64'(enc_a),  64'(2'b11));
    for (int k = 0; k < 6; k++) tick();
    chk("s4_enc_frozen", 64'(enc_a),  64'(2'b11));
    chk("s4_done_clear", 64'(done_a), 64'(0));

    // abort on accept edge ignored; abort on step edge T+15: three edges
    abort = 1'b1;
    offer(1'b1, 16'd100, 16'd5);
    abort = 1'b0;
    chk("s5_busy_accept", 64'(busy_a), 64'(1));
    for (int k = 1; k <= 15; k++) begin
      if (k == 15) abort = 1'b1;
      tick();
      if (k == 5)  chk("s5_enc_k5",  64'(enc_a), 64'(2'b10));
      if (k == 10) chk("s5_enc_k10", 64'(enc_a), 64'(2'b00));
    end
    abort = 1'b0;
    chk("s5_enc",  64'(enc_a),  64'(2'b01));
    chk("s5_pos",  64'(pos_a),  64'(5));
    chk("s5_done", 64'(done_a), 64'(1));
    chk("s5_busy", 64'(busy_a), 64'(0));

    // 4-bit position wrap: 7 forward edges then one more
    do_reset();
    offer(1'b1, 16'd7, 16'd1);
    for (int k = 0; k < 7; k++) tick();
    chk("s6_pos_b7", 64'(pos_b), 64'(4'd7));
    chk("s6_enc_b7", 64'(enc_b), 64'(2'b10));
    chk("s6_done",   64'(done_b), 64'(1));
    offer(1'b1, 16'd1, 16'd1);
    tick();
    chk("s6_pos_wrap", 64'(pos_b), 64'(4'h8));
    chk("s6_pos_a8",   64'(pos_a), 64'(8));
    chk("s6_enc_b8",   64'(enc_b), 64'(2'b00));

    // reset mid-run: everything cleared, no done pulse
    offer(1'b1, 16'd10, 16'd2);
    tick();
    tick();
    chk("s7_enc_run", 64'(enc_a), 64'(2'b01));
    #3 rst_n = 1'b0;
    #1;
    chk("s7_enc_rst",   64'(enc_a),   64'(2'b00));
    chk("s7_pos_rst",   64'(pos_a),   64'(0));
    chk("s7_busy_rst",  64'(busy_a),  64'(0));
    chk("s7_ready_rst", 64'(ready_a), 64'(0));
    tick();
    chk("s7_done_rst", 64'(done_a), 64'(0));
    rst_n = 1'b1;
    tick();
    chk("s7_ready_post", 64'(ready_a), 64'(1));
    chk("s7_done_post",  64'(done_a),  64'(0));
    chk("s7_enc_post",   64'(enc_a),   64'(2'b00));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
